// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, used by the datapath and the control decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  // Compares need A - B, so they steer the shared adder into subtract mode.
  function automatic logic op_uses_sub(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu64_if.sv
// Operand/result bundle between the ALU and its user.
interface alu64_if;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  ALUOp;
  logic [63:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  modport master (output A, B, ALUOp, input result, zero, negative, carry, overflow);
  modport slave  (input A, B, ALUOp, output result, zero, negative, carry, overflow);
endinterface

// File: rtl/alu_adder64.sv
// Shared 64-bit add/subtract path; subtract is A + ~B + 1 so carry means "no borrow".
module alu_adder64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_sub,
  output logic [63:0] o_sum,
  output logic        o_carry,
  output logic        o_overflow
);
  logic [63:0] w_b;
  logic [64:0] w_full;

  assign w_b        = i_sub ? ~i_b : i_b;
  assign w_full     = {1'b0, i_a} + {1'b0, w_b} + {64'd0, i_sub};
  assign o_sum      = w_full[63:0];
  assign o_carry    = w_full[64];
  assign o_overflow = (i_a[63] == w_b[63]) && (o_sum[63] != i_a[63]);
endmodule

// File: rtl/alu64.sv
// 64-bit ALU: combinational result, flags registered one cycle behind the result.
module alu64
  import alu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  alu64_if.slave bus
);
  logic [63:0] w_sum;
  logic        w_cout;
  logic        w_ovf;
  logic        w_sub;
  logic [5:0]  w_shamt;
  logic [63:0] w_result;
  logic        w_valid;
  logic        w_carry_d;
  logic        w_ovf_d;
  logic        w_zero_d;
  logic        w_neg_d;
  logic        r_zero;
  logic        r_negative;
  logic        r_carry;
  logic        r_overflow;

  assign w_sub   = op_uses_sub(bus.ALUOp);
  assign w_shamt = bus.B[5:0];

  alu_adder64 u_adder (
    .i_a        (bus.A),
    .i_b        (bus.B),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_carry    (w_cout),
    .o_overflow (w_ovf)
  );

  // Result mux and next-state flags; unused encodings force everything to zero.
  always_comb begin
    w_result  = 64'd0;
    w_valid   = 1'b1;
    w_carry_d = 1'b0;
    w_ovf_d   = 1'b0;
    case (alu_op_e'(bus.ALUOp))
      ALU_AND:  w_result = bus.A & bus.B;
      ALU_OR:   w_result = bus.A | bus.B;
      ALU_XOR:  w_result = bus.A ^ bus.B;
      ALU_SLL:  w_result = bus.A << w_shamt;
      ALU_SRL:  w_result = bus.A >> w_shamt;
      ALU_SRA:  w_result = $unsigned($signed(bus.A) >>> w_shamt);
      ALU_ADD, ALU_SUB: begin
        w_result  = w_sum;
        w_carry_d = w_cout;
        w_ovf_d   = w_ovf;
      end
      // Signed less-than is the true sign of A - B, i.e. sum sign corrected by overflow.
      ALU_SLT:  w_result = {63'd0, w_sum[63] ^ w_ovf};
      ALU_SLTU: w_result = {63'd0, ~w_cout};
      default: begin
        w_result = 64'd0;
        w_valid  = 1'b0;
      end
    endcase
    w_zero_d = w_valid & (w_result == 64'd0);
    w_neg_d  = w_valid & w_result[63];
  end

  // Flag register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_zero     <= w_zero_d;
      r_negative <= w_neg_d;
      r_carry    <= w_carry_d;
      r_overflow <= w_ovf_d;
    end
  end

  assign bus.result   = w_result;
  assign bus.zero     = r_zero;
  assign bus.negative = r_negative;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_alu64.sv
// Scoreboard bench for alu64: driver pushes model predictions, monitor pops and compares.
module tb_alu64;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  alu64_if bus ();

  alu64 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model written from the arithmetic definitions of each operation.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    exp_t e;
    logic [64:0] w;
    logic [64:0] s;
    int sh;
    e    = '0;
    e.op = op;
    sh   = int'(b[5:0]);
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[63:0];
        e.c = w[64];
        s = {a[63], a} + {b[63], b};
        e.v = s[64] ^ s[63];
      end
      4'd3: e.res = a ^ b;
      4'd4: e.res = a << sh;
      4'd5: e.res = a >> sh;
      4'd6: begin
        e.res = a - b;
        e.c = (a >= b);
        s = {a[63], a} - {b[63], b};
        e.v = s[64] ^ s[63];
      end
      4'd7: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd8: e.res = (a < b) ? 64'd1 : 64'd0;
      4'd9: e.res = $signed(a) >>> sh;
      default: e.res = 64'd0;
    endcase
    if (op <= 4'd9) begin
      e.z = (e.res == 64'd0);
      e.n = e.res[63];
    end
    return e;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.ALUOp = op;
    q.push_back(model(a, b, op));
  endtask

  task automatic check_flags(input string name, input logic [3:0] want);
    logic [3:0] got;
    got = {bus.zero, bus.negative, bus.carry, bus.overflow};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: zncv got %b want %b", name, got, want);
    end
  endtask

  // Monitor: result checked mid-cycle, flags checked just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.result !== e.res) begin
          n_bad++;
          $display("FAIL result op=%h A=%h B=%h: got %h want %h", e.op, bus.A, bus.B, bus.result, e.res);
        end
        @(posedge clk);
        #1;
        check_flags($sformatf("flags op=%h", e.op), {e.z, e.n, e.c, e.v});
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    exp_t e;
    int waited;

    rst = 1'b1;
    bus.A = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.B = 64'd1;
    bus.ALUOp = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    check_flags("reset_state", 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    issue(64'd10, 64'd10, 4'd2);
    issue(64'd30, 64'd10, 4'd2);
    issue(64'd30, 64'd10, 4'd6);
    issue(64'h3FC, 64'h7, 4'd0);
    issue(64'h3FC, 64'h7, 4'd1);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd2);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd7);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd8);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 4'd9);
    issue(64'h8000_0000_0000_0001, 64'd0, 4'd4);
    issue(64'h8000_0000_0000_0001, 64'hFFC0, 4'd5);
    issue(64'h8000_0000_0000_0000, 64'd63, 4'd5);
    issue(64'd5, 64'd5, 4'd6);
    issue(64'd5, 64'd6, 4'd6);
    issue(64'h8000_0000_0000_0000, 64'd1, 4'd6);
    for (int k = 10; k < 16; k++) issue(64'hDEAD_BEEF_0000_0001, 64'd3, 4'(k));

    for (int i = 0; i < 400; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: b = a;
        1: b[5:0] = 6'd0;
        2: b[5:0] = 6'd63;
        3: a = 64'h8000_0000_0000_0000;
        4: a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      issue(a, b, op);
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end

    // Asynchronous reset in the middle of a cycle with nonzero flags.
    @(negedge clk);
    bus.A = 64'h7FFF_FFFF_FFFF_FFFF;
    bus.B = 64'd1;
    bus.ALUOp = 4'd2;
    e = model(bus.A, bus.B, bus.ALUOp);
    @(posedge clk);
    #1;
    check_flags("pre_reset_flags", {e.z, e.n, e.c, e.v});
    #2;
    rst = 1'b1;
    #1;
    check_flags("async_reset_flags", 4'b0000);
    n_cmp++;
    if (bus.result !== e.res) begin
      n_bad++;
      $display("FAIL reset_result: got %h want %h", bus.result, e.res);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_flags("post_reset_reload", {e.z, e.n, e.c, e.v});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu64.md
ALU64 -- requirements
Module: alu64

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for the flag register.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset of the flag register.
REQ-004 Port A, input, 64 bits: operand A (rs1).
REQ-005 Port B, input, 64 bits: operand B (rs2 or immediate).
REQ-006 Port ALUOp, input, 4 bits: operation select.
REQ-007 Port result, output, 64 bits: combinational operation result.
REQ-008 Port zero, output, 1 bit: registered flag, result == 0.
REQ-009 Port negative, output, 1 bit: registered flag, result[63].
REQ-010 Port carry, output, 1 bit: registered carry-out of ADD, or NOT borrow of SUB; 0 for other ops.
REQ-011 Port overflow, output, 1 bit: registered signed overflow of ADD/SUB; 0 for other ops.

Function
REQ-012 result SHALL be purely combinational from A, B and ALUOp, with zero clock latency and no dependence on clk or rst.
REQ-013 ALUOp 0000 SHALL give A AND B.
REQ-014 ALUOp 0001 SHALL give A OR B.
REQ-015 ALUOp 0010 SHALL give A + B modulo 2^64.
REQ-016 ALUOp 0011 SHALL give A XOR B.
REQ-017 ALUOp 0100 SHALL give A << B[5:0] (logical); B[63:6] are ignored.
REQ-018 ALUOp 0101 SHALL give A >> B[5:0] (logical, zero fill).
REQ-019 ALUOp 0110 SHALL give A - B modulo 2^64.
REQ-020 ALUOp 0111 (SLT) SHALL give 1 if signed A < signed B, else 0, zero-extended to 64 bits.
REQ-021 ALUOp 1000 (SLTU) SHALL give 1 if unsigned A < unsigned B, else 0.
REQ-022 ALUOp 1001 SHALL give A >>> B[5:0] (arithmetic, sign fill).
REQ-023 ALUOp 1010-1111 SHALL give result 0 and all flag inputs 0.
REQ-024 Shift amount 0 SHALL return A unchanged; shift amount 63 SHALL be legal.
REQ-025 Overflow on ADD SHALL be 1 when A[63]==B[63] and result[63]!=A[63].
REQ-026 Overflow on SUB SHALL be 1 when A[63]!=B[63] and result[63]!=A[63].
REQ-027 SUB SHALL be computed as A + ~B + 1, and carry SHALL be 1 when A >= B unsigned.
REQ-028 Flags SHALL be computed from the current result and sampled into the flag register on every rising clk edge; they lag result by one cycle.

Reset
REQ-029 While rst is 1, zero, negative, carry and overflow SHALL be 0, immediately and regardless of clk.
REQ-030 After rst is released, the first rising clk edge SHALL load the flags normally.
REQ-031 rst SHALL NOT affect result.

Structure
REQ-032 The ALUOp encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA) SHALL be constants in a shared package alu_pkg, which the control decoder also uses.
REQ-033 One sub-module, alu_adder64, SHALL implement the shared add/subtract path with carry and overflow outputs; ADD, SUB, SLT and SLTU SHALL all use it.

Verification
REQ-034 A=10, B=10, ALUOp=0010 -> result=20; the next clk gives zero=0, carry=0, overflow=0.
REQ-035 A=30, B=10: ALUOp=0010 -> result=40; ALUOp=0110 -> result=20, carry=1.
REQ-036 A=0x3FC, B=0x7: ALUOp=0000 -> result=0x4; ALUOp=0001 -> result=0x3FF.
REQ-037 A=0x7FFF_FFFF_FFFF_FFFF, B=1, ALUOp=0010 -> result=0x8000_0000_0000_0000; after clk, overflow=1 and negative=1.
REQ-038 A=0xFFFF_FFFF_FFFF_FFFF (-1), B=1: ALUOp=0111 -> 1; ALUOp=1000 -> 0; ALUOp=1001 with B=63 -> all ones.
REQ-039 Set flags nonzero, then assert rst mid-cycle -> all flags are 0 before the next clk edge, and result is unchanged.
